// File: rtl/sd_block_writer.sv
// sd_block_writer
//   Collects one SD block of bytes from an upstream producer into a local
//   buffer, then drives the write half of sd_controller to commit that block
//   at a 512-byte-aligned address. Runs on clk_100mhz. The controller status
//   lines come from the clk_25mhz domain and are synchronized here.
//
// Ports
//   clk_100mhz             system clock
//   rst_n                  synchronous active-low reset
//   start                  one-cycle pulse, begins a transfer (IDLE only)
//   block_addr[31:0]       SD byte address, low 9 bits forced to zero
//   in_data[7:0]/in_valid  upstream byte stream
//   in_ready               byte accepted this cycle when in_valid is high
//   busy                   high in every state except IDLE
//   done                   one-cycle pulse when the block is committed
//   error                  sticky timeout flag, cleared by accepted start
//   sd_ready               controller ready (clk_25mhz domain)
//   sd_ready_for_next_byte controller byte request (clk_25mhz domain)
//   sd_wr/sd_din/sd_addr   write request, data byte and address to controller
module sd_block_writer #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic        clk_100mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] block_addr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  output logic [31:0] sd_addr
);

  localparam int unsigned AW = $clog2(BLOCK_BYTES);
  localparam int unsigned IW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BLOCK_BYTES - 1);
  localparam logic [IW-1:0] IDX_END  = IW'(BLOCK_BYTES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_SEND,
    S_FINISH,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic [IW-1:0]       w_idx_inc;
  logic [TW-1:0]       r_tmo;
  logic [TW-1:0]       w_tmo_nxt;
  logic                r_sd_wr;
  logic                w_wr_nxt;
  logic                r_error;
  logic                w_err_nxt;
  logic [31:0]         r_sd_addr;
  logic [31:0]         w_addr_nxt;
  logic [7:0]          r_sd_din;
  logic [SYNC_STAGES-1:0] r_rdy_sync;
  logic [SYNC_STAGES-1:0] r_rfnb_sync;
  logic                r_rfnb_d;
  logic [7:0]          r_buf [BLOCK_BYTES];

  logic w_rdy_s;
  logic w_rfnb_s;
  logic w_rfnb_fall;
  logic w_rfnb_edge;
  logic w_accept;
  logic w_phase;

  assign w_rdy_s     = r_rdy_sync[SYNC_STAGES-1];
  assign w_rfnb_s    = r_rfnb_sync[SYNC_STAGES-1];
  // A falling request line means the controller has consumed sd_din.
  assign w_rfnb_fall = r_rfnb_d & ~w_rfnb_s;
  assign w_rfnb_edge = r_rfnb_d ^ w_rfnb_s;
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_phase     = (r_state == S_ISSUE) || (r_state == S_SEND) || (r_state == S_FINISH);

  assign in_ready = (r_state == S_LOAD);
  assign w_accept = in_valid & in_ready;
  assign busy     = (r_state != S_IDLE);
  // A dedicated one-cycle state keeps busy high through the done pulse so
  // both fall on the same edge.
  assign done     = (r_state == S_DONE);
  assign error    = r_error;
  assign sd_wr    = r_sd_wr;
  assign sd_din   = r_sd_din;
  assign sd_addr  = r_sd_addr;

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      r_rdy_sync  <= '0;
      r_rfnb_sync <= '0;
      r_rfnb_d    <= 1'b0;
    end else begin
      r_rdy_sync[0]  <= sd_ready;
      r_rfnb_sync[0] <= sd_ready_for_next_byte;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_rdy_sync[k]  <= r_rdy_sync[k-1];
        r_rfnb_sync[k] <= r_rfnb_sync[k-1];
      end
      r_rfnb_d <= w_rfnb_s;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wr_nxt    = r_sd_wr;
    w_err_nxt   = r_error;
    w_addr_nxt  = r_sd_addr;
    w_tmo_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_addr_nxt  = block_addr & ~32'h0000_01FF;
          w_err_nxt   = 1'b0;
          w_idx_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          if (r_idx == IDX_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_ISSUE;
          end else begin
            w_idx_nxt = w_idx_inc;
          end
        end
      end
      S_ISSUE: begin
        if (!r_sd_wr) begin
          if (w_rdy_s) w_wr_nxt = 1'b1;
        end else if (!w_rdy_s) begin
          w_wr_nxt    = 1'b0;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_rfnb_fall) begin
          w_idx_nxt = w_idx_inc;
          if (w_idx_inc == IDX_END) w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: begin
        if (w_rdy_s) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_phase && (r_tmo == TMO_LAST)) begin
      w_state_nxt = S_IDLE;
      w_wr_nxt    = 1'b0;
      w_err_nxt   = 1'b1;
    end
    if (w_phase && (w_state_nxt == r_state) && !w_rfnb_edge) begin
      w_tmo_nxt = r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_tmo     <= '0;
      r_sd_wr   <= 1'b0;
      r_error   <= 1'b0;
      r_sd_addr <= '0;
      r_sd_din  <= '0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_tmo     <= w_tmo_nxt;
      r_sd_wr   <= w_wr_nxt;
      r_error   <= w_err_nxt;
      r_sd_addr <= w_addr_nxt;
      // Registered read: sd_din follows the index one cycle after it moves.
      // In FINISH the index sits at BLOCK_BYTES, so the last byte is held.
      if ((r_state == S_ISSUE) || (r_state == S_SEND)) begin
        r_sd_din <= r_buf[r_idx[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_n && w_accept) begin
      r_buf[r_idx[AW-1:0]] <= in_data;
    end
  end

endmodule

// File: tb/tb_sd_block_writer.sv
module tb_sd_block_writer;

  logic        clk_100mhz = 1'b0;
  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] block_addr;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic        sd_ready;
  logic        sd_rfnb;
  logic        sd_wr;
  logic [7:0]  sd_din;
  logic [31:0] sd_addr;

  int checks = 0;
  int failures = 0;

  logic [7:0] tx [512];
  logic [7:0] m_cap [1024];
  int m_cnt = 0;
  bit m_stuck = 1'b0;
  bit m_kill = 1'b0;
  bit m_busy = 1'b0;

  int done_cnt = 0;
  int done_nobusy = 0;
  int busy_linger = 0;
  bit prev_done = 1'b0;

  sd_block_writer #(
    .BLOCK_BYTES   (512),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk_100mhz            (clk_100mhz),
    .rst_n                 (rst_n),
    .start                 (start),
    .block_addr            (block_addr),
    .in_data               (in_data),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .busy                  (busy),
    .done                  (done),
    .error                 (error),
    .sd_ready              (sd_ready),
    .sd_ready_for_next_byte(sd_rfnb),
    .sd_wr                 (sd_wr),
    .sd_din                (sd_din),
    .sd_addr               (sd_addr)
  );

  initial forever #5 clk_100mhz = ~clk_100mhz;
  initial begin
    #2;
    forever #20 clk_25 = ~clk_25;
  end

  // Behavioural write half of sd_controller in the 25 MHz domain.
  initial begin : ctrl_model
    sd_ready = 1'b1;
    sd_rfnb  = 1'b0;
    forever begin
      @(posedge clk_25);
      if (sd_wr === 1'b1 && !m_stuck) begin
        m_busy   = 1'b1;
        sd_ready = 1'b0;
        repeat (2) @(posedge clk_25);
        for (int b = 0; b < 512; b++) begin
          if (m_kill) break;
          sd_rfnb = 1'b1;
          repeat (2) @(posedge clk_25);
          if (m_cnt < 1024) m_cap[m_cnt] = sd_din;
          m_cnt++;
          sd_rfnb = 1'b0;
          @(posedge clk_25);
        end
        repeat (2) @(posedge clk_25);
        sd_ready = 1'b1;
        m_kill   = 1'b0;
        m_busy   = 1'b0;
      end
    end
  end

  initial begin : done_mon
    forever begin
      @(negedge clk_100mhz);
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b1) done_nobusy++;
      end
      if (prev_done && done !== 1'b1 && busy !== 1'b0) busy_linger++;
      prev_done = (done === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a);
    @(negedge clk_100mhz);
    start      = 1'b1;
    block_addr = a;
    in_valid   = 1'b1;
    in_data    = 8'hEE;
    chk("in_ready_on_start", in_ready, 1'b0);
    @(negedge clk_100mhz);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load(input bit toggle, input string tag);
    int acc = 0;
    int cyc = 0;
    while (acc < 512 && cyc < 5000) begin
      @(negedge clk_100mhz);
      in_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      in_data  = tx[acc];
      if (in_valid && in_ready === 1'b1) acc++;
      cyc++;
    end
    chk({tag, "_accepted"}, acc, 512);
    @(negedge clk_100mhz);
    in_valid = 1'b1;
    in_data  = 8'h99;
    chk({tag, "_in_ready_after_last"}, in_ready, 1'b0);
    @(negedge clk_100mhz);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int cyc = 0;
    while (done_cnt == base && cyc < 20000) begin
      @(negedge clk_100mhz);
      cyc++;
    end
    repeat (20) @(negedge clk_100mhz);
    chk({tag, "_done_pulses"}, done_cnt - base, 1);
    chk({tag, "_busy_at_done"}, done_nobusy, 0);
    chk({tag, "_busy_fall_with_done"}, busy_linger, 0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_in_ready_idle"}, in_ready, 1'b0);
  endtask

  task automatic chk_data(input string tag);
    int nbad = 0;
    for (int i = 0; i < 512; i++) begin
      if (m_cap[i] !== tx[i]) nbad++;
    end
    chk({tag, "_bytes_seen"}, m_cnt, 512);
    chk({tag, "_bytes_wrong"}, nbad, 0);
  endtask

  initial begin : stim
    int n;
    int base;
    rst_n      = 1'b0;
    start      = 1'b0;
    block_addr = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_sd_wr", sd_wr, 1'b0);
    chk("rst_sd_din", sd_din, 8'h00);
    chk("rst_sd_addr", sd_addr, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_100mhz);

    // Happy path.
    for (int i = 0; i < 512; i++) tx[i] = 8'(i);
    m_cnt = 0;
    do_start(32'h0000_0A37);
    chk("t1_sd_addr", sd_addr, 32'h0000_0A00);
    chk("t1_busy", busy, 1'b1);
    load(1'b0, "t1");
    wait_done("t1");
    chk_data("t1");

    // Backpressure plus an ignored start during SEND.
    for (int i = 0; i < 512; i++) tx[i] = 8'(i * 7 + 3);
    m_cnt = 0;
    do_start(32'h1234_5FFF);
    load(1'b1, "t2");
    n = 0;
    while (m_cnt < 10 && n < 2000) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("t2_busy_in_send", busy, 1'b1);
    start      = 1'b1;
    block_addr = 32'hFFFF_F000;
    @(negedge clk_100mhz);
    start = 1'b0;
    @(negedge clk_100mhz);
    chk("t2_addr_kept", sd_addr, 32'h1234_5E00);
    chk("t2_in_ready_send", in_ready, 1'b0);
    wait_done("t2");
    chk_data("t2");
    chk("t2_addr_final", sd_addr, 32'h1234_5E00);

    // Timeout: the controller never drops ready.
    m_stuck = 1'b1;
    base = done_cnt;
    do_start(32'h0000_0400);
    load(1'b0, "t3");
    n = 0;
    while (sd_wr !== 1'b1 && n < 100) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("t3_sd_wr_raised", sd_wr, 1'b1);
    n = 0;
    while (error !== 1'b1 && n < 1100) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("t3_timeout_window", (n >= 995 && n <= 1003), 1'b1);
    chk("t3_error", error, 1'b1);
    chk("t3_sd_wr_dropped", sd_wr, 1'b0);
    chk("t3_busy", busy, 1'b0);
    repeat (5) @(negedge clk_100mhz);
    chk("t3_no_done", done_cnt - base, 0);
    chk("t3_error_sticky", error, 1'b1);
    m_stuck = 1'b0;

    // Reset in the middle of SEND; this start also clears the error.
    for (int i = 0; i < 512; i++) tx[i] = ~8'(i);
    m_cnt = 0;
    do_start(32'h0000_0600);
    chk("t4_error_cleared", error, 1'b0);
    load(1'b0, "t4");
    n = 0;
    while (m_cnt < 100 && n < 5000) begin
      @(negedge clk_100mhz);
      n++;
    end
    rst_n = 1'b0;
    @(negedge clk_100mhz);
    rst_n = 1'b1;
    chk("t4_sd_wr", sd_wr, 1'b0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_in_ready", in_ready, 1'b0);
    chk("t4_error", error, 1'b0);
    chk("t4_sd_addr", sd_addr, 32'h0);
    m_kill = 1'b1;
    n = 0;
    while (m_busy && n < 1000) begin
      @(negedge clk_100mhz);
      n++;
    end
    chk("t4_model_idle", m_busy, 1'b0);
    repeat (5) @(negedge clk_100mhz);

    // Full block after reset with distinctive first and last bytes.
    for (int i = 0; i < 512; i++) tx[i] = 8'(i) ^ 8'h3C;
    tx[0]   = 8'h5A;
    tx[511] = 8'hA5;
    m_cnt = 0;
    do_start(32'hABCD_E1FF);
    chk("t5_sd_addr", sd_addr, 32'hABCD_E000);
    load(1'b0, "t5");
    wait_done("t5");
    chk("t5_first_byte", m_cap[0], 8'h5A);
    chk("t5_last_byte", m_cap[511], 8'hA5);
    chk_data("t5");
    chk("t5_error", error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
